// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for the execute stage.
// Captures operand magnitudes when a div/mod op is presented in IDLE, produces one
// quotient bit per cycle in BUSY, applies sign fix-up on the last iteration and
// holds the registered result in DONE until the execute stage acknowledges it.
//
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration when the divisor
// is zero or |src1| < |src2| (result known immediately, complete one cycle later).
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   div_enable   valid div/mod op held by execute stage until ack
//   div_sign     1 = signed operands
//   div_op       [0] quotient requested, [1] remainder requested
//   div_src1     dividend
//   div_src2     divisor
//   div_ack      execute stage advances this cycle
//   div_complete result valid (DONE)
//   div_result   registered quotient or remainder
//   div_busy     sequencer not idle
module div_ctrl #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div_enable,
    input  logic                 div_sign,
    input  logic [1:0]           div_op,
    input  logic [DIV_WIDTH-1:0] div_src1,
    input  logic [DIV_WIDTH-1:0] div_src2,
    input  logic                 div_ack,
    output logic                 div_complete,
    output logic [DIV_WIDTH-1:0] div_result,
    output logic                 div_busy
);

    localparam int CW = $clog2(DIV_WIDTH + 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_INIT = CW'(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] ZERO_W   = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONES_W   = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CW-1:0]        count_r;
    logic [DIV_WIDTH-1:0] dvd_r;        // dividend magnitude, shifts left; quotient fills from LSB
    logic [DIV_WIDTH-1:0] dvs_r;
    logic [DIV_WIDTH-1:0] rem_r;
    logic [DIV_WIDTH-1:0] src1_r;       // raw dividend, the divide-by-zero remainder
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 op_rem_r;
    logic                 dvs_zero_r;
    logic [DIV_WIDTH-1:0] result_r;
    logic                 complete_r;
    logic                 busy_r;

    logic [DIV_WIDTH-1:0] abs1_s;
    logic [DIV_WIDTH-1:0] abs2_s;
    logic                 op_rem_s;
    logic [DIV_WIDTH:0]   rem_shift_s;
    logic                 ge_s;
    logic [DIV_WIDTH-1:0] rem_nxt_s;
    logic [DIV_WIDTH-1:0] quo_nxt_s;
    logic [DIV_WIDTH-1:0] final_s;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        negate = ~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x,
                                                       input logic sgn);
        if (sgn && x[DIV_WIDTH-1]) begin
            magnitude = negate(x);
        end else begin
            magnitude = x;
        end
    endfunction

    // Operand magnitudes, restoring step and sign fix-up of the last step.
    always_comb begin
        abs1_s      = magnitude(div_src1, div_sign);
        abs2_s      = magnitude(div_src2, div_sign);
        // An illegal op encoding (both bits) falls back to the quotient.
        op_rem_s    = div_op[1] & ~div_op[0];
        rem_shift_s = {rem_r, dvd_r[DIV_WIDTH-1]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
        if (ge_s) begin
            rem_nxt_s = rem_shift_s[DIV_WIDTH-1:0] - dvs_r;
        end else begin
            rem_nxt_s = rem_shift_s[DIV_WIDTH-1:0];
        end
        quo_nxt_s = {dvd_r[DIV_WIDTH-2:0], ge_s};
        if (dvs_zero_r) begin
            final_s = op_rem_r ? src1_r : ONES_W;
        end else if (op_rem_r) begin
            final_s = neg_r_r ? negate(rem_nxt_s) : rem_nxt_s;
        end else begin
            final_s = neg_q_r ? negate(quo_nxt_s) : quo_nxt_s;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    logic                 early_s;
    logic [DIV_WIDTH-1:0] early_res_s;

    // Cases whose result is known without iterating.
    always_comb begin
        early_s = (abs2_s == ZERO_W) || (abs1_s < abs2_s);
        if (op_rem_s) begin
            early_res_s = div_src1;
        end else if (abs2_s == ZERO_W) begin
            early_res_s = ONES_W;
        end else begin
            early_res_s = ZERO_W;
        end
    end
`endif

    // Next-state logic; dropping div_enable squashes the op from BUSY or DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_enable) begin
`ifdef DIV_EARLY_OUT_EN
                    state_nxt_s = early_s ? DONE : BUSY;
`else
                    state_nxt_s = BUSY;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (!div_enable) begin
                    state_nxt_s = IDLE;
                end else if (count_r == CNT_ONE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (!div_enable || div_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            complete_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            complete_r <= (state_nxt_s == DONE);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= {CW{1'b0}};
            dvd_r      <= ZERO_W;
            dvs_r      <= ZERO_W;
            rem_r      <= ZERO_W;
            src1_r     <= ZERO_W;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            op_rem_r   <= 1'b0;
            dvs_zero_r <= 1'b0;
            result_r   <= ZERO_W;
        end else if (state_r == IDLE && div_enable) begin
            count_r    <= CNT_INIT;
            dvd_r      <= abs1_s;
            dvs_r      <= abs2_s;
            rem_r      <= ZERO_W;
            src1_r     <= div_src1;
            neg_q_r    <= div_sign & (div_src1[DIV_WIDTH-1] ^ div_src2[DIV_WIDTH-1]);
            neg_r_r    <= div_sign & div_src1[DIV_WIDTH-1];
            op_rem_r   <= op_rem_s;
            dvs_zero_r <= (div_src2 == ZERO_W);
`ifdef DIV_EARLY_OUT_EN
            if (early_s) begin
                result_r <= early_res_s;
            end
`endif
        end else if (state_r == BUSY && div_enable) begin
            count_r <= count_r - CNT_ONE;
            dvd_r   <= quo_nxt_s;
            rem_r   <= rem_nxt_s;
            if (count_r == CNT_ONE) begin
                result_r <= final_s;
            end
        end
    end

    assign div_complete = complete_r;
    assign div_busy     = busy_r;
    assign div_result   = result_r;

endmodule
